// File: rtl/digital_tube_decoder.sv
// rtl/digital_tube_decoder.sv - recovers per-digit hex values from a scanned seven-segment bus
// Optional feature: define DIGITAL_TUBE_DECODER_SYNC_EN for a 2-flop input synchronizer.
module digital_tube_decoder #(
  parameter int STABLE_CYC = 3,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] csn,
  input  logic [6:0] abcdefg,
  output logic [3:0] single_digit,
  output logic [3:0] ten_digit,
  output logic [3:0] hundred_digit,
  output logic [3:0] kilo_digit,
  output logic [3:0] digit_valid,
  output logic       frame_done,
  output logic       seg_err
);

  typedef enum logic [1:0] {IDLE, QUAL, HOLD} state_t;

  logic [3:0] s_csn;
  logic [6:0] s_seg;

`ifdef DIGITAL_TUBE_DECODER_SYNC_EN
  logic [3:0] csn_m, csn_s;
  logic [6:0] seg_m, seg_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csn_m <= 4'hF;
      csn_s <= 4'hF;
      seg_m <= '0;
      seg_s <= '0;
    end else begin
      csn_m <= csn;
      csn_s <= csn_m;
      seg_m <= abcdefg;
      seg_s <= seg_m;
    end
  end

  assign s_csn = csn_s;
  assign s_seg = seg_s;
`else
  assign s_csn = csn;
  assign s_seg = abcdefg;
`endif

  // Returns {pattern_ok, value}; anything outside the 16 glyphs is rejected.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h7E:   decode = {1'b1, 4'h0};
      7'h30:   decode = {1'b1, 4'h1};
      7'h6D:   decode = {1'b1, 4'h2};
      7'h79:   decode = {1'b1, 4'h3};
      7'h33:   decode = {1'b1, 4'h4};
      7'h5B:   decode = {1'b1, 4'h5};
      7'h5F:   decode = {1'b1, 4'h6};
      7'h70:   decode = {1'b1, 4'h7};
      7'h7F:   decode = {1'b1, 4'h8};
      7'h7B:   decode = {1'b1, 4'h9};
      7'h77:   decode = {1'b1, 4'hA};
      7'h1F:   decode = {1'b1, 4'hB};
      7'h4E:   decode = {1'b1, 4'hC};
      7'h3D:   decode = {1'b1, 4'hD};
      7'h4F:   decode = {1'b1, 4'hE};
      7'h47:   decode = {1'b1, 4'hF};
      default: decode = 5'b0_0000;
    endcase
  endfunction

  logic [10:0]      s, prev_s;
  logic [3:0]       sel;
  logic             one_hot;
  logic             same;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             capture;
  logic [4:0]       dec;
  logic [3:0]       mask, mask_set;
  logic [3:0]       digit_q [4];

  assign s        = {s_csn, s_seg};
  assign sel      = ~s_csn;
  assign one_hot  = (sel != 4'b0000) && ((sel & (sel - 4'd1)) == 4'b0000);
  assign same     = (s == prev_s);
  assign dec      = decode(s_seg);
  assign mask_set = mask | sel;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    if (!one_hot) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (state == HOLD && same) begin
      state_nxt = HOLD;
    end else begin
      if (state == IDLE || !same) cnt_nxt = CNT_W'(1);
      else                        cnt_nxt = cnt + CNT_W'(1);
      // A fresh value reaching the threshold on its first sample covers STABLE_CYC = 1.
      if (cnt_nxt == CNT_W'(STABLE_CYC)) begin
        capture   = 1'b1;
        state_nxt = HOLD;
      end else begin
        state_nxt = QUAL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      prev_s <= {4'hF, 7'h00};
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      prev_s <= s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) digit_q[i] <= 4'h0;
      digit_valid <= 4'b0000;
      mask        <= 4'b0000;
      frame_done  <= 1'b0;
      seg_err     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      seg_err    <= 1'b0;
      if (capture) begin
        if (dec[4]) begin
          for (int i = 0; i < 4; i++) begin
            if (sel[i]) digit_q[i] <= dec[3:0];
          end
          digit_valid <= digit_valid | sel;
          if (mask_set == 4'hF) begin
            frame_done <= 1'b1;
            mask       <= 4'b0000;
          end else begin
            mask <= mask_set;
          end
        end else begin
          digit_valid <= digit_valid & ~sel;
          seg_err     <= 1'b1;
        end
      end
    end
  end

  assign single_digit  = digit_q[0];
  assign ten_digit     = digit_q[1];
  assign hundred_digit = digit_q[2];
  assign kilo_digit    = digit_q[3];

endmodule

// File: tb/tb_digital_tube_decoder.sv
// tb/tb_digital_tube_decoder.sv - table, directed and random checks of digital_tube_decoder
// Honours DIGITAL_TUBE_DECODER_SYNC_EN for the expected latency and model input pipeline.
module tb_digital_tube_decoder;
  localparam int STABLE_CYC = 3;
`ifdef DIGITAL_TUBE_DECODER_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int LAT = STABLE_CYC + SYNC_LAT;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] csn;
  logic [6:0] abcdefg;
  logic [3:0] single_digit, ten_digit, hundred_digit, kilo_digit, digit_valid;
  logic       frame_done, seg_err;
  logic [3:0] s1_single, s1_ten, s1_hundred, s1_kilo, s1_valid;
  logic       s1_fd, s1_se;

  digital_tube_decoder #(.STABLE_CYC(STABLE_CYC), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .csn(csn), .abcdefg(abcdefg),
    .single_digit(single_digit), .ten_digit(ten_digit),
    .hundred_digit(hundred_digit), .kilo_digit(kilo_digit),
    .digit_valid(digit_valid), .frame_done(frame_done), .seg_err(seg_err)
  );

  digital_tube_decoder #(.STABLE_CYC(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .csn(csn), .abcdefg(abcdefg),
    .single_digit(s1_single), .ten_digit(s1_ten),
    .hundred_digit(s1_hundred), .kilo_digit(s1_kilo),
    .digit_valid(s1_valid), .frame_done(s1_fd), .seg_err(s1_se)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_fd, n_se;

  logic [6:0] pat [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                           7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Reference model: a slot is captured when an identical one-hot-low sample has been seen
  // exactly STABLE_CYC times in a row.
  logic [10:0] m_p1, m_p2, m_prev;
  int          m_run;
  logic [15:0] m_dig;
  logic [3:0]  m_valid, m_mask;
  logic        m_fd, m_se;

  function automatic int low_pos(input logic [3:0] c);
    int n = 0, p = -1;
    for (int i = 0; i < 4; i++) if (!c[i]) begin n++; p = i; end
    return (n == 1) ? p : -1;
  endfunction

  function automatic int lookup(input logic [6:0] g);
    for (int i = 0; i < 16; i++) if (pat[i] == g) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_p1 = {4'hF, 7'h00}; m_p2 = {4'hF, 7'h00}; m_prev = {4'hF, 7'h00};
    m_run = 0; m_dig = '0; m_valid = '0; m_mask = '0; m_fd = 0; m_se = 0;
  endtask

  task automatic model_edge();
    logic [10:0] s;
    int pos, v;
    if (SYNC_LAT != 0) begin
      s = m_p2; m_p2 = m_p1; m_p1 = {csn, abcdefg};
    end else begin
      s = {csn, abcdefg};
    end
    if (s != m_prev) m_run = 1;
    else if (m_run < 1000) m_run++;
    m_prev = s;
    m_fd = 0; m_se = 0;
    pos = low_pos(s[10:7]);
    if (pos >= 0 && m_run == STABLE_CYC) begin
      v = lookup(s[6:0]);
      if (v >= 0) begin
        m_dig[pos*4 +: 4] = v[3:0];
        m_valid[pos] = 1'b1;
        m_mask[pos] = 1'b1;
        if (m_mask == 4'hF) begin m_fd = 1; m_mask = 4'h0; end
      end else begin
        m_valid[pos] = 1'b0;
        m_se = 1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic step(input logic [3:0] c, input logic [6:0] g);
    csn = c; abcdefg = g;
    @(posedge clk);
    model_edge();
    #1;
    if (frame_done) n_fd++;
    if (seg_err) n_se++;
    tests++;
    if ({kilo_digit, hundred_digit, ten_digit, single_digit} !== m_dig ||
        digit_valid !== m_valid || frame_done !== m_fd || seg_err !== m_se) begin
      fails++;
      $display("FAIL model t=%0t: got d=%h v=%b fd=%b se=%b want d=%h v=%b fd=%b se=%b",
               $time, {kilo_digit, hundred_digit, ten_digit, single_digit}, digit_valid,
               frame_done, seg_err, m_dig, m_valid, m_fd, m_se);
    end
  endtask

  task automatic slot(input logic [3:0] c, input logic [6:0] g, input int len);
    for (int i = 0; i < len; i++) step(c, g);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("async_reset", {kilo_digit, hundred_digit, ten_digit, single_digit, digit_valid,
                        frame_done, seg_err}, '0);
    model_reset();
    csn = 4'hF; abcdefg = 7'h00;
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    n_fd = 0; n_se = 0;
  endtask

  function automatic logic [3:0] sel_of(input int pos);
    logic [3:0] one = 4'b0001;
    return ~(one << pos);
  endfunction

  typedef struct {
    logic [6:0] seg;
    logic [3:0] val;
    logic       ok;
  } vec_t;

  vec_t       vecs [18];
  logic [15:0] exp_dig;
  logic [15:0] got_dig;
  int          lat0, lat1;

  initial begin
    rst = 1'b0; csn = 4'hF; abcdefg = 7'h00;
    n_fd = 0; n_se = 0;
    model_reset();
    for (int i = 0; i < 16; i++) vecs[i] = '{pat[i], 4'(i), 1'b1};
    vecs[16] = '{7'h00, 4'h0, 1'b0};
    vecs[17] = '{7'h7D, 4'h0, 1'b0};

    do_reset();

    // Decode table, one position at a time with blanking between slots.
    exp_dig = '0;
    for (int i = 0; i < 18; i++) begin
      int pos = i % 4;
      step(4'hF, 7'h00);
      slot(sel_of(pos), vecs[i].seg, LAT + 1);
      got_dig = {kilo_digit, hundred_digit, ten_digit, single_digit};
      if (vecs[i].ok) exp_dig[pos*4 +: 4] = vecs[i].val;
      chk($sformatf("table_digit[%0d]", i), got_dig[pos*4 +: 4], exp_dig[pos*4 +: 4]);
      chk($sformatf("table_valid[%0d]", i), digit_valid[pos], vecs[i].ok);
    end

    // Reset asserted in the middle of a qualifying slot.
    slot(4'b1110, 7'h30, 2);
    do_reset();

    // Ideal scan: three frames of 1,2,3,4.
    for (int f = 0; f < 3; f++) begin
      slot(4'b1110, 7'h30, 4); slot(4'b1101, 7'h6D, 4);
      slot(4'b1011, 7'h79, 4); slot(4'b0111, 7'h33, 4);
    end
    slot(4'hF, 7'h00, 4);
    chk("scan_digits", {kilo_digit, hundred_digit, ten_digit, single_digit}, 16'h4321);
    chk("scan_valid", digit_valid, 4'hF);
    chk("scan_frames", n_fd, 3);
    chk("scan_seg_err", n_se, 0);

    // Short glitch on the single slot must not capture an 8.
    do_reset();
    slot(4'b1110, 7'h5B, 4); slot(4'b1110, 7'h7F, 2); slot(4'b1101, 7'h6D, 4);
    slot(4'hF, 7'h00, 4);
    chk("glitch_single", single_digit, 4'h5);
    chk("glitch_frames", n_fd, 0);

    // Invalid pattern on the ten slot inside a frame.
    do_reset();
    slot(4'b1110, 7'h30, 4); slot(4'b1101, 7'h6D, 4);
    slot(4'b1011, 7'h79, 4); slot(4'b0111, 7'h33, 4);
    slot(4'hF, 7'h00, 3);
    chk("inv_first_frame", n_fd, 1);
    n_fd = 0; n_se = 0;
    slot(4'b1110, 7'h30, 4); slot(4'b1101, 7'h00, 5);
    slot(4'b1011, 7'h79, 4); slot(4'b0111, 7'h33, 4);
    slot(4'hF, 7'h00, 3);
    chk("inv_seg_err", n_se, 1);
    chk("inv_frames", n_fd, 0);
    chk("inv_valid", digit_valid, 4'b1101);
    chk("inv_ten_kept", ten_digit, 4'h2);

    // Multi-select is ignored.
    n_fd = 0; n_se = 0;
    slot(4'b1100, 7'h7F, 10);
    chk("multi_digits", {kilo_digit, hundred_digit, ten_digit, single_digit}, 16'h4321);
    chk("multi_valid", digit_valid, 4'b1101);
    chk("multi_pulses", n_fd + n_se, 0);

    // Latency from input change to output update, for STABLE_CYC and for STABLE_CYC = 1.
    do_reset();
    slot(4'hF, 7'h00, 3);
    lat0 = -1; lat1 = -1;
    for (int k = 1; k <= 20; k++) begin
      step(4'b1011, 7'h4F);
      if (lat0 < 0 && hundred_digit == 4'hE) lat0 = k;
      if (lat1 < 0 && s1_hundred == 4'hE) lat1 = k;
    end
    chk("latency", lat0, LAT);
    chk("latency_stable1", lat1, 1 + SYNC_LAT);
    chk("stable1_once", s1_valid, 4'b0100);

    // One-cycle slot captured only by the STABLE_CYC = 1 instance.
    slot(4'hF, 7'h00, 2);
    slot(4'b0111, 7'h30, 1);
    slot(4'hF, 7'h00, 4);
    chk("stable1_short_slot", s1_kilo, 4'h1);
    chk("stable3_short_slot", kilo_digit, 4'h0);

    // Randomized scans checked against the model every cycle.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int r = $urandom_range(0, 9);
      logic [3:0] c;
      logic [6:0] g;
      if (r < 7)       c = sel_of($urandom_range(0, 3));
      else if (r == 7) c = 4'hF;
      else             c = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) != 0) g = pat[$urandom_range(0, 15)];
      else                           g = 7'($urandom_range(0, 127));
      slot(c, g, $urandom_range(1, 6));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
